// File: rtl/buscador_instrucciones.sv
// Instruction fetch unit: reads one- or two-word instructions from a word-addressed
// memory with a fixed read latency and hands them to a decoder with a valid/ready handshake.
module buscador_instrucciones #(
   parameter int unsigned LATENCIA         = 1,
   parameter logic [3:0]  CODIGO_INMEDIATO = 4'h4
) (
   input  logic        Reloj,
   input  logic        Reinicio,
   input  logic [15:0] DatoMemoria,
   output logic [15:0] DireccionMemoria,
   output logic        HabilitarSalida,
   output logic        HabilitarEscritura,
   input  logic        Saltar,
   input  logic [15:0] DireccionSalto,
   input  logic        Listo,
   output logic        Valida,
   output logic [15:0] Instruccion,
   output logic [15:0] Inmediato,
   output logic [15:0] ContadorPrograma
);

   localparam int unsigned ANCHO_ESPERA = 4;

   typedef enum logic [2:0] {
      INICIO,
      PEDIR_OP,
      ESPERAR_OP,
      PEDIR_INM,
      ESPERAR_INM,
      ENTREGAR
   } estado_t;

   estado_t                   estado_q;
   logic [ANCHO_ESPERA-1:0]   espera_q;
   logic                      ultimo_c;
   logic                      doble_c;
   logic [15:0]               pc_sig_c;
   logic [15:0]               pc_inm_c;

   // Wait-cycle end detection and next-PC arithmetic (16-bit wrap is intentional).
   always_comb begin
      ultimo_c = (espera_q == ANCHO_ESPERA'(LATENCIA - 1));
      doble_c  = (Instruccion[15:12] == CODIGO_INMEDIATO);
      pc_inm_c = ContadorPrograma + 16'd1;
      pc_sig_c = ContadorPrograma + (doble_c ? 16'd2 : 16'd1);
   end

   // The unit never writes memory.
   assign HabilitarEscritura = 1'b0;

   // Fetch FSM with registered outputs; reset beats jump, jump beats everything else.
   always_ff @(posedge Reloj) begin
      if (!Reinicio) begin
         estado_q         <= INICIO;
         espera_q         <= '0;
         ContadorPrograma <= 16'h0000;
         DireccionMemoria <= 16'h0000;
         Instruccion      <= 16'h0000;
         Inmediato        <= 16'h0000;
         Valida           <= 1'b0;
         HabilitarSalida  <= 1'b0;
      end else if (Saltar) begin
         estado_q         <= PEDIR_OP;
         espera_q         <= '0;
         ContadorPrograma <= DireccionSalto;
         DireccionMemoria <= DireccionSalto;
         HabilitarSalida  <= 1'b1;
         Valida           <= 1'b0;
      end else begin
         case (estado_q)
            INICIO: begin
               estado_q         <= PEDIR_OP;
               DireccionMemoria <= ContadorPrograma;
               HabilitarSalida  <= 1'b1;
            end
            PEDIR_OP: begin
               estado_q <= ESPERAR_OP;
               espera_q <= '0;
            end
            ESPERAR_OP: begin
               if (ultimo_c) begin
                  espera_q    <= '0;
                  Instruccion <= DatoMemoria;
                  if (DatoMemoria[15:12] == CODIGO_INMEDIATO) begin
                     estado_q         <= PEDIR_INM;
                     DireccionMemoria <= pc_inm_c;
                  end else begin
                     estado_q        <= ENTREGAR;
                     Inmediato       <= 16'h0000;
                     HabilitarSalida <= 1'b0;
                     Valida          <= 1'b1;
                  end
               end else begin
                  espera_q <= espera_q + ANCHO_ESPERA'(1);
               end
            end
            PEDIR_INM: begin
               estado_q <= ESPERAR_INM;
               espera_q <= '0;
            end
            ESPERAR_INM: begin
               if (ultimo_c) begin
                  espera_q        <= '0;
                  Inmediato       <= DatoMemoria;
                  estado_q        <= ENTREGAR;
                  HabilitarSalida <= 1'b0;
                  Valida          <= 1'b1;
               end else begin
                  espera_q <= espera_q + ANCHO_ESPERA'(1);
               end
            end
            ENTREGAR: begin
               if (Listo) begin
                  estado_q         <= PEDIR_OP;
                  ContadorPrograma <= pc_sig_c;
                  DireccionMemoria <= pc_sig_c;
                  HabilitarSalida  <= 1'b1;
                  Valida           <= 1'b0;
               end
            end
            default: begin
               estado_q        <= INICIO;
               HabilitarSalida <= 1'b0;
               Valida          <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_buscador_instrucciones.sv
// Bench for buscador_instrucciones: two instances (latency 1 and 3) share stimulus and a
// memory image; a timeline model predicts every output on every cycle.
module tb_buscador_instrucciones;

   logic              Reloj;
   logic              Reinicio;
   logic              Saltar;
   logic [15:0]       DireccionSalto;
   logic              Listo;
   logic [1:0][15:0]  dato;
   logic [1:0][15:0]  addr;
   logic [1:0]        en;
   logic [1:0]        we;
   logic [1:0]        v;
   logic [1:0][15:0]  inst;
   logic [1:0][15:0]  inm;
   logic [1:0][15:0]  pc;

   logic [15:0] mem [0:65535];

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // model state per instance
   logic [15:0] m_pc   [2];
   int          m_k    [2];
   bit          m_idle [2];
   bit          m_rst  [2];

   buscador_instrucciones #(.LATENCIA(1)) dut0 (
      .Reloj(Reloj), .Reinicio(Reinicio), .DatoMemoria(dato[0]),
      .DireccionMemoria(addr[0]), .HabilitarSalida(en[0]), .HabilitarEscritura(we[0]),
      .Saltar(Saltar), .DireccionSalto(DireccionSalto), .Listo(Listo),
      .Valida(v[0]), .Instruccion(inst[0]), .Inmediato(inm[0]), .ContadorPrograma(pc[0]));

   buscador_instrucciones #(.LATENCIA(3)) dut1 (
      .Reloj(Reloj), .Reinicio(Reinicio), .DatoMemoria(dato[1]),
      .DireccionMemoria(addr[1]), .HabilitarSalida(en[1]), .HabilitarEscritura(we[1]),
      .Saltar(Saltar), .DireccionSalto(DireccionSalto), .Listo(Listo),
      .Valida(v[1]), .Instruccion(inst[1]), .Inmediato(inm[1]), .ContadorPrograma(pc[1]));

   // Asynchronous-read memory; drives garbage when not enabled.
   assign dato[0] = en[0] ? mem[addr[0]] : 16'hDEAD;
   assign dato[1] = en[1] ? mem[addr[1]] : 16'hDEAD;

   initial begin
      Reloj = 1'b0;
      forever #5 Reloj = ~Reloj;
   end

   function automatic int lat_of(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic int words_at(input logic [15:0] a);
      logic [15:0] w;
      w = mem[a];
      return (w[15:12] == 4'h4) ? 2 : 1;
   endfunction

   task automatic chk(input string nm, input int i, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", nm, i, cyc, act, exp);
      end
   endtask

   // Advance the timeline model across one rising edge using the inputs present at that edge.
   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         int total;
         total = words_at(m_pc[i]) * (1 + lat_of(i));
         if (!Reinicio) begin
            m_rst[i] = 1; m_idle[i] = 1; m_pc[i] = 16'h0000; m_k[i] = 0;
         end else begin
            m_rst[i] = 0;
            if (Saltar) begin
               m_pc[i] = DireccionSalto; m_idle[i] = 0; m_k[i] = 0;
            end else if (m_idle[i]) begin
               m_idle[i] = 0; m_k[i] = 0;
            end else if (m_k[i] >= total && Listo) begin
               m_pc[i] = m_pc[i] + 16'(words_at(m_pc[i])); m_k[i] = 0;
            end else if (m_k[i] < total) begin
               m_k[i] = m_k[i] + 1;
            end
         end
      end
   endtask

   // Compare every output of both instances with the model.
   task automatic compare_all();
      for (int i = 0; i < 2; i++) begin
         int nw, total;
         nw    = words_at(m_pc[i]);
         total = nw * (1 + lat_of(i));
         chk("we", i, {15'b0, we[i]}, 16'd0);
         chk("pc", i, pc[i], m_pc[i]);
         if (m_idle[i]) begin
            chk("en_idle", i, {15'b0, en[i]}, 16'd0);
            chk("v_idle", i, {15'b0, v[i]}, 16'd0);
            if (m_rst[i]) begin
               chk("addr_rst", i, addr[i], 16'h0000);
               chk("inst_rst", i, inst[i], 16'h0000);
               chk("inm_rst", i, inm[i], 16'h0000);
            end
         end else if (m_k[i] < total) begin
            chk("en_fetch", i, {15'b0, en[i]}, 16'd1);
            chk("v_fetch", i, {15'b0, v[i]}, 16'd0);
            chk("addr_fetch", i, addr[i], m_pc[i] + 16'(m_k[i] / (1 + lat_of(i))));
         end else begin
            chk("en_deliver", i, {15'b0, en[i]}, 16'd0);
            chk("v_deliver", i, {15'b0, v[i]}, 16'd1);
            chk("inst", i, inst[i], mem[m_pc[i]]);
            chk("inm", i, inm[i], (nw == 2) ? mem[m_pc[i] + 16'd1] : 16'h0000);
         end
      end
   endtask

   task automatic tick();
      @(posedge Reloj);
      model_edge();
      @(negedge Reloj);
      cyc++;
      compare_all();
   endtask

   task automatic reset_cycles(input int n);
      Reinicio = 1'b0;
      Saltar   = 1'b0;
      repeat (n) tick();
      cyc = 0;
   endtask

   initial begin
      Reinicio = 1'b0; Saltar = 1'b0; DireccionSalto = 16'h0000; Listo = 1'b1;
      for (int a = 0; a < 65536; a++) begin
         logic [15:0] w;
         w = 16'($urandom);
         if ($urandom_range(0, 2) == 0) w[15:12] = 4'h4;
         mem[a] = w;
      end
      for (int i = 0; i < 2; i++) begin
         m_pc[i] = 16'h0000; m_k[i] = 0; m_idle[i] = 1; m_rst[i] = 1;
      end

      // Two-word then one-word fetch, with a decoder stall.
      mem[0] = 16'h4000; mem[1] = 16'h0017; mem[2] = 16'h1234;
      reset_cycles(3);
      Listo = 1'b1; Reinicio = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         tick();
         if (cyc == 1) begin chk("lit_en_c1", 0, {15'b0, en[0]}, 16'd1); chk("lit_addr_c1", 0, addr[0], 16'h0000); end
         if (cyc == 5) begin
            chk("lit_v_c5", 0, {15'b0, v[0]}, 16'd1);
            chk("lit_inst_c5", 0, inst[0], 16'h4000);
            chk("lit_inm_c5", 0, inm[0], 16'h0017);
         end
         if (cyc == 6) chk("lit_pc_c6", 0, pc[0], 16'h0002);
         if (cyc == 8) begin
            chk("lit_v_c8", 0, {15'b0, v[0]}, 16'd1);
            chk("lit_inm_c8", 0, inm[0], 16'h0000);
            chk("lit_v3_c8", 1, {15'b0, v[1]}, 16'd0);
         end
         if (cyc == 9) chk("lit_v3_c9", 1, {15'b0, v[1]}, 16'd1);
         if (cyc == 12) begin
            chk("lit_v_c12", 0, {15'b0, v[0]}, 16'd1);
            chk("lit_pc_c12", 0, pc[0], 16'h0002);
         end
         if (cyc == 13) chk("lit_pc_c13", 0, pc[0], 16'h0003);
         Listo = (cyc >= 8 && cyc <= 11) ? 1'b0 : 1'b1;
      end

      // Reset lands mid-ESPERAR_OP; then a single-word instruction at 0.
      mem[0] = 16'h1234;
      reset_cycles(2);
      chk("lit_pc_rst", 1, pc[1], 16'h0000);
      chk("lit_en_rst", 1, {15'b0, en[1]}, 16'd0);
      Reinicio = 1'b1; Listo = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (cyc == 1 || cyc == 2) chk("lit_en_rd", 0, {15'b0, en[0]}, 16'd1);
         if (cyc == 3) begin
            chk("lit_en_c3", 0, {15'b0, en[0]}, 16'd0);
            chk("lit_v_c3", 0, {15'b0, v[0]}, 16'd1);
            chk("lit_inm_c3", 0, inm[0], 16'h0000);
         end
         if (cyc == 4) begin
            chk("lit_pc_c4", 0, pc[0], 16'h0001);
            chk("lit_en3_c4", 1, {15'b0, en[1]}, 16'd1);
         end
         if (cyc == 5) chk("lit_v3_c5", 1, {15'b0, v[1]}, 16'd1);
      end

      // Jump during ESPERAR_INM abandons the instruction.
      mem[0] = 16'h4000; mem[1] = 16'h0017;
      reset_cycles(2);
      Reinicio = 1'b1; Listo = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         tick();
         Saltar = 1'b0;
         if (cyc == 4) begin
            chk("lit_addr_inm", 0, addr[0], 16'h0001);
            Saltar = 1'b1; DireccionSalto = 16'h000A;
         end
         if (cyc == 5) begin
            chk("lit_v_jmp", 0, {15'b0, v[0]}, 16'd0);
            chk("lit_addr_jmp", 0, addr[0], 16'h000A);
            chk("lit_pc_jmp", 0, pc[0], 16'h000A);
         end
         if (cyc == 6) chk("lit_v_jmp6", 0, {15'b0, v[0]}, 16'd0);
      end

      // Jump from INICIO to FFFF with a two-word instruction: immediate wraps to 0000.
      mem[16'hFFFF] = 16'h4ABC; mem[0] = 16'h0123;
      reset_cycles(2);
      Reinicio = 1'b1; Listo = 1'b1; Saltar = 1'b1; DireccionSalto = 16'hFFFF;
      for (int c = 1; c <= 7; c++) begin
         tick();
         Saltar = 1'b0;
         if (cyc == 1) begin chk("lit_pc_wrap", 0, pc[0], 16'hFFFF); chk("lit_addr_wrap", 0, addr[0], 16'hFFFF); end
         if (cyc == 3) chk("lit_addr_inm_wrap", 0, addr[0], 16'h0000);
         if (cyc == 5) begin
            chk("lit_inst_wrap", 0, inst[0], 16'h4ABC);
            chk("lit_inm_wrap", 0, inm[0], 16'h0123);
         end
         if (cyc == 6) chk("lit_pc_next_wrap", 0, pc[0], 16'h0001);
      end

      // Randomized traffic: stalls, jumps (often near the top of memory) and resets.
      for (int c = 0; c < 4000; c++) begin
         Reinicio = ($urandom_range(0, 199) != 0);
         Listo    = ($urandom_range(0, 9) < 7);
         Saltar   = ($urandom_range(0, 39) == 0);
         DireccionSalto = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 2))
                                                      : 16'($urandom);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
